// File: rtl/minesweeper_pkg.sv
// minesweeper_pkg: shared FSM encoding, cell-count type and board defaults.
package minesweeper_pkg;

    localparam int DEF_GRID_SIZE  = 3;
    localparam int DEF_STATE_SIZE = 4;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} seq_state_t;

    typedef logic [DEF_STATE_SIZE-1:0] cell_count_t;

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neighbor_mask.sv
// neighbor_mask: in-grid 8-neighbour mask of cell (row, col); edges never wrap.
module neighbor_mask
    import minesweeper_pkg::*;
#(
    parameter int GRID_SIZE = DEF_GRID_SIZE,
    localparam int N = GRID_SIZE * GRID_SIZE,
    localparam int CW = coord_w(GRID_SIZE)
) (
    input  logic [CW-1:0] row,
    input  logic [CW-1:0] col,
    output logic [N-1:0]  mask
);

    always_comb begin
        mask = '0;
        for (int r = 0; r < GRID_SIZE; r++)
            for (int c = 0; c < GRID_SIZE; c++)
                mask[r*GRID_SIZE+c] = (r != int'(row) || c != int'(col)) &&
                                      (r - int'(row) <= 1) && (int'(row) - r <= 1) &&
                                      (c - int'(col) <= 1) && (int'(col) - c <= 1);
    end

endmodule

// File: rtl/reveal_sequencer.sv
// reveal_sequencer: reveals the cursor cell(s) and flood-fills zero-count
// regions by repeated raster passes until a pass adds nothing.
module reveal_sequencer
    import minesweeper_pkg::*;
#(
    parameter int GRID_SIZE  = DEF_GRID_SIZE,
    parameter int STATE_SIZE = DEF_STATE_SIZE,
    localparam int N  = GRID_SIZE * GRID_SIZE,
    localparam int CW = coord_w(GRID_SIZE),
    localparam int IW = coord_w(N)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N-1:0]          cursorGrid,
    input  logic [N-1:0]          bombGrid,
    input  logic [STATE_SIZE*N-1:0] states,
    input  logic [N-1:0]          revealIn,
    output logic [N-1:0]          revealOut,
    output logic                  busy,
    output logic                  done,
    output logic                  hitBomb
);

    seq_state_t state, state_n;
    logic [CW-1:0] row, col;
    logic [IW-1:0] idx;
    logic changed;
    logic [N-1:0] zero_map, nb, scan_reveal;
    logic expand, chg_now, last, load_hit, load_scan;

    neighbor_mask #(.GRID_SIZE(GRID_SIZE)) u_nb (.row(row), .col(col), .mask(nb));

    always_comb begin
        zero_map = '0;
        for (int i = 0; i < N; i++)
            zero_map[i] = states[i*STATE_SIZE +: STATE_SIZE] == '0;
    end

    assign load_hit    = |(cursorGrid & bombGrid);
    assign load_scan   = !load_hit && |(cursorGrid & zero_map);
    assign expand      = revealOut[idx] && !bombGrid[idx] && zero_map[idx];
    assign scan_reveal = expand ? (revealOut | nb) : revealOut;
    assign chg_now     = changed || (scan_reveal != revealOut);
    assign last        = idx == IW'(N - 1);
    assign busy        = state != IDLE;
    assign done        = state == DONE;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: state_n = start ? LOAD : IDLE;
            LOAD: state_n = load_scan ? SCAN : DONE;
            SCAN: state_n = (last && !chg_now) ? DONE : SCAN;
            DONE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            revealOut <= '0;
            hitBomb   <= 1'b0;
            row       <= '0;
            col       <= '0;
            idx       <= '0;
            changed   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == LOAD) begin
                revealOut <= revealIn | cursorGrid;
                hitBomb   <= load_hit;
                row       <= '0;
                col       <= '0;
                idx       <= '0;
                changed   <= 1'b0;
            end else if (state == SCAN) begin
                revealOut <= scan_reveal;
                // Row/col counters track idx so no divide is needed for the mask.
                if (last) begin
                    row     <= '0;
                    col     <= '0;
                    idx     <= '0;
                    changed <= 1'b0;
                end else begin
                    changed <= chg_now;
                    idx     <= idx + IW'(1);
                    col     <= (col == CW'(GRID_SIZE - 1)) ? '0 : col + CW'(1);
                    row     <= (col == CW'(GRID_SIZE - 1)) ? row + CW'(1) : row;
                end
            end
        end
    end

endmodule

// File: doc/reveal_sequencer.md
REVEAL_SEQUENCER -- requirements
Module: reveal_sequencer

Interface
REQ-001 SHALL have parameter GRID_SIZE, default 3, meaning board edge length; N = GRID_SIZE*GRID_SIZE cells, row-major, cell i = row*GRID_SIZE+col.
REQ-002 SHALL have parameter STATE_SIZE, default 4, meaning width of the per-cell adjacent-bomb count.
REQ-003 SHALL have port clock  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  request to reveal the cursor cell; sampled only in IDLE.
REQ-006 SHALL have port cursorGrid  in  N  one-hot cursor position.
REQ-007 SHALL have port bombGrid  in  N  bomb map; held stable while busy.
REQ-008 SHALL have port states  in  STATE_SIZE*N  adjacent counts; cell i at bits [i*STATE_SIZE +: STATE_SIZE]; held stable while busy.
REQ-009 SHALL have port revealIn  in  N  current reveal map, captured on start.
REQ-010 SHALL have port revealOut  out  N  updated reveal map, valid when done pulses.
REQ-011 SHALL have port busy  out  1  high from LOAD through DONE inclusive.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port hitBomb  out  1  a cursor cell holds a bomb; valid with done, held until next start.

Function
REQ-014 SHALL implement states IDLE, LOAD, SCAN, DONE.
REQ-015 IDLE: start=1 SHALL go to LOAD; start otherwise ignored, including all start pulses while busy.
REQ-016 LOAD (1 cycle): revealOut <= revealIn | cursorGrid; hitBomb <= |(cursorGrid & bombGrid); scan index <= 0; changed <= 0.
REQ-017 LOAD exit: to DONE if hitBomb, cursorGrid==0, or the cursor cell count is nonzero; otherwise to SCAN.
REQ-018 SCAN: one cell per cycle, index 0..N-1 via row/col counters (no divide); if revealOut[i]=1, bombGrid[i]=0 and count[i]==0, OR its in-grid 8-neighbours into revealOut, setting changed if any new bit.
REQ-019 Neighbour masks SHALL NOT wrap across row or column edges; corner cells have 3 neighbours, edge cells 5, interior cells 8.
REQ-020 At index N-1: changed=1 starts a new pass (index 0, changed cleared); changed=0 goes to DONE.
REQ-021 Updates made earlier in a pass SHALL be visible to later indices of the same pass.
REQ-022 Multiple cursor bits SHALL reveal all of them; bomb check ORs across them; scan proceeds only if not hitBomb and any cursor cell count is zero.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; revealOut and hitBomb hold until next LOAD.
REQ-024 Latency: with P scan passes, done SHALL assert 2+P*N cycles after the start sample edge; P=0 when SCAN is skipped; P <= N.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, revealOut=0, hitBomb=0, busy=0, done=0, index=0, changed=0, from any state, including mid-SCAN.
REQ-026 A start coincident with reset SHALL be dropped.

Structure
REQ-027 State encodings, the cell-count type (STATE_SIZE bits) and default GRID_SIZE/STATE_SIZE SHALL live in shared package minesweeper_pkg.
REQ-028 A combinational sub-module neighbor_mask (row, col -> N-bit in-grid 8-neighbour mask) SHALL be instantiated once.

Verification (3x3, bombs at 5 and 8, counts [0,1,1,0,2,x,0,2,x], revealIn=0)
REQ-029 cursor=0x001, start -> SCAN 2 passes, done at +20 cycles, revealOut=0x0DB, hitBomb=0.
REQ-030 cursor=0x002, start -> no SCAN, done at +2, revealOut=0x002, hitBomb=0.
REQ-031 cursor=0x020, start -> done at +2, revealOut=0x020, hitBomb=1.
REQ-032 cursor=0x001, start, then start pulses every cycle while busy -> single done at +20, result 0x0DB.
REQ-033 cursor=0x001, start, reset at +6 -> next cycle busy=0, revealOut=0, no done pulse; new start completes normally.
REQ-034 revealIn=0x0DB, cursor=0x040 -> scan adds nothing, 1 pass, done at +11, revealOut=0x0DB.
